// File: rtl/sha256_engine_arbiter.sv
// Round-robin arbiter that time-shares one SHA-256 compression engine among
// N_REQ message streams. It chains the intermediate hash and returns tagged digests.
module sha256_engine_arbiter #(
    parameter int           N_REQ = 4,
    parameter int           IDW   = $clog2(N_REQ),
    parameter logic [255:0] IV    = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ-1:0]     req_first,
    input  logic [N_REQ-1:0]     req_last,
    input  logic [N_REQ*512-1:0] req_block,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 eng_start,
    output logic                 eng_clr,
    output logic [255:0]         eng_h,
    output logic [511:0]         eng_m,
    input  logic                 eng_done,
    input  logic [255:0]         eng_h_out,
    output logic                 dig_valid,
    input  logic                 dig_ready,
    output logic [255:0]         dig_data,
    output logic [IDW-1:0]       dig_id,
    output logic                 busy,
    output logic                 err
);

    // Handshakes: a block moves when req_valid[i] & req_ready[i] at a rising clk edge;
    // a digest moves when dig_valid & dig_ready. Valid never waits on ready, and
    // dig_data/dig_id hold steady while dig_valid is high and dig_ready is low.

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_CLR,
        S_OUT
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   owner;
    logic             lock;
    logic             last_q;
    logic             done_q;
    logic [255:0]     chain;

    logic             sel_found;
    logic [IDW-1:0]   sel_idx;
    logic             sel_first;
    logic             sel_last;
    logic [511:0]     sel_block;
    logic             done_rise;
    logic [IDW-1:0]   owner_nxt;

    assign done_rise = eng_done & ~done_q;
    assign busy      = (state != S_IDLE) || lock;
    assign owner_nxt = (owner == IDW'(N_REQ - 1)) ? '0 : owner + 1'b1;

    // Search from rr_ptr upward; while a message is open only its owner is eligible.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_first = 1'b0;
        sel_last  = 1'b0;
        sel_block = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int j;
            j = (int'(rr_ptr) + k) % N_REQ;
            if (!sel_found && req_valid[j] && (!lock || j == int'(owner))) begin
                sel_found = 1'b1;
                sel_idx   = IDW'(j);
                sel_first = req_first[j];
                sel_last  = req_last[j];
                sel_block = req_block[j*512 +: 512];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        eng_start = 1'b0;
        eng_clr   = 1'b0;
        dig_valid = 1'b0;
        case (state)
            S_IDLE: begin
                if (sel_found) begin
                    req_ready[sel_idx] = 1'b1;
                    state_nxt          = S_START;
                end
            end
            S_START: begin
                eng_start = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (done_rise) begin
                    state_nxt = S_CLR;
                end
            end
            S_CLR: begin
                eng_clr   = 1'b1;
                state_nxt = last_q ? S_OUT : S_IDLE;
            end
            S_OUT: begin
                dig_valid = 1'b1;
                if (dig_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= '0;
            owner    <= '0;
            lock     <= 1'b0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
            chain    <= IV;
            eng_h    <= '0;
            eng_m    <= '0;
            dig_data <= '0;
            dig_id   <= '0;
            err      <= 1'b0;
        end else begin
            done_q <= eng_done;
            case (state)
                S_IDLE: begin
                    if (sel_found) begin
                        owner  <= sel_idx;
                        eng_m  <= sel_block;
                        last_q <= sel_last;
                        lock   <= 1'b1;
                        eng_h  <= sel_first ? IV : chain;
                        // first must equal !lock: a restart mid-message or an unopened continuation
                        if (sel_first == lock) begin
                            err <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (done_rise) begin
                        chain <= eng_h_out;
                    end
                end
                S_CLR: begin
                    if (last_q) begin
                        dig_data <= chain;
                        dig_id   <= owner;
                    end
                end
                S_OUT: begin
                    if (dig_ready) begin
                        lock   <= 1'b0;
                        rr_ptr <= owner_nxt;
                        chain  <= IV;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_engine_arbiter.sv
// Directed bench for sha256_engine_arbiter: a behavioural SHA-256 engine, queued
// requester feeders and a digest scoreboard checked with immediate assertions.
module tb_sha256_engine_arbiter;

    localparam int N_REQ = 4;
    localparam int IDW   = 2;
    localparam logic [255:0] IV      = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] DIG_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_448 = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic                 clk;
    logic                 rst;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_first;
    logic [N_REQ-1:0]     req_last;
    logic [N_REQ*512-1:0] req_block;
    logic [N_REQ-1:0]     req_ready;
    logic                 eng_start;
    logic                 eng_clr;
    logic [255:0]         eng_h;
    logic [511:0]         eng_m;
    logic                 eng_done;
    logic [255:0]         eng_h_out;
    logic                 dig_valid;
    logic                 dig_ready;
    logic [255:0]         dig_data;
    logic [IDW-1:0]       dig_id;
    logic                 busy;
    logic                 err;

    sha256_engine_arbiter #(.N_REQ(N_REQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_first (req_first),
        .req_last  (req_last),
        .req_block (req_block),
        .req_ready (req_ready),
        .eng_start (eng_start),
        .eng_clr   (eng_clr),
        .eng_h     (eng_h),
        .eng_m     (eng_m),
        .eng_done  (eng_done),
        .eng_h_out (eng_h_out),
        .dig_valid (dig_valid),
        .dig_ready (dig_ready),
        .dig_data  (dig_data),
        .dig_id    (dig_id),
        .busy      (busy),
        .err       (err)
    );

    int checks    = 0;
    int errors    = 0;
    int n_dig     = 0;
    int lock_base = 0;
    logic chk_lock = 1'b0;

    logic [IDW+255:0] exp_q[$];
    logic [513:0]     src_q[N_REQ][$];
    logic [255:0]     eng_h_log[$];
    logic [511:0]     acc_blk = '0;

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] m);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
        for (int t = 0; t < 16; t++) w[t] = m[511-32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        {a, b, c, d, e, f, g, hh} = h;
        for (int t = 0; t < 64; t++) begin
            s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
            t1 = hh + s1 + ((e & f) ^ (~e & g)) + K[t] + w[t];
            s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
            t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
                h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r = {r[479:0], 32'($urandom())};
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send(input int r, input logic [511:0] blk, input logic f, input logic l);
        src_q[r].push_back({f, l, blk});
    endtask

    task automatic expect_dig(input int r, input logic [255:0] d);
        exp_q.push_back({IDW'(r), d});
    endtask

    task automatic wait_digs(input int n, input string tag);
        int cyc;
        cyc = 0;
        while (n_dig < n && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk(tag, 512'(n_dig), 512'(n));
    endtask

    // ---------------- requester feeder ----------------
    initial begin
        logic [N_REQ-1:0] rdy_s;
        logic [513:0]     cur;
        req_valid = '0;
        req_first = '0;
        req_last  = '0;
        req_block = '0;
        forever begin
            @(negedge clk);
            rdy_s = req_ready;
            if (req_ready != '0) begin
                chk("ready_onehot", 512'($onehot0(req_ready)), 512'(1));
                chk("ready_without_valid", 512'(req_ready & ~req_valid), '0);
            end
            if (chk_lock && req_ready[3]) chk("t4_lock_held", 512'(n_dig), 512'(lock_base + 1));
            @(posedge clk);
            #1;
            for (int i = 0; i < N_REQ; i++) begin
                if (rdy_s[i] && src_q[i].size() > 0) begin
                    cur     = src_q[i].pop_front();
                    acc_blk = cur[511:0];
                end
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (src_q[i].size() > 0) begin
                    cur                    = src_q[i][0];
                    req_valid[i]           = 1'b1;
                    req_first[i]           = cur[513];
                    req_last[i]            = cur[512];
                    req_block[i*512 +: 512] = cur[511:0];
                end else begin
                    req_valid[i] = 1'b0;
                    req_first[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end
            end
        end
    end

    // ---------------- behavioural engine ----------------
    initial begin
        logic [255:0] e_h;
        logic [511:0] e_m;
        int           e_cnt;
        logic         e_busy;
        eng_done  = 1'b0;
        eng_h_out = '0;
        e_busy    = 1'b0;
        e_cnt     = 0;
        e_h       = '0;
        e_m       = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                eng_done  = 1'b0;
                eng_h_out = '0;
                e_busy    = 1'b0;
            end else begin
                if (eng_clr) begin
                    chk("eng_m_at_clr", eng_m, acc_blk);
                    eng_done = 1'b0;
                end
                if (eng_start) begin
                    chk("eng_m_at_start", eng_m, acc_blk);
                    e_h = eng_h;
                    e_m = eng_m;
                    eng_h_log.push_back(eng_h);
                    e_cnt  = $urandom_range(2, 6);
                    e_busy = 1'b1;
                end else if (e_busy) begin
                    if (e_cnt == 0) begin
                        eng_done  = 1'b1;
                        eng_h_out = sha_compress(e_h, e_m);
                        e_busy    = 1'b0;
                    end else begin
                        e_cnt--;
                    end
                end
            end
        end
    end

    // ---------------- digest scoreboard ----------------
    initial begin
        logic [IDW+255:0] e;
        forever begin
            @(negedge clk);
            if (!rst && dig_valid && dig_ready) begin
                if (exp_q.size() > 0) e = exp_q.pop_front();
                else e = 'x;
                chk("dig_data", 512'(dig_data), 512'(e[255:0]));
                chk("dig_id", 512'(dig_id), 512'(e[IDW+255:256]));
                n_dig++;
            end
        end
    end

    // ---------------- directed sequence ----------------
    logic [511:0] blk_abc, b448_1, b448_2, ra, rb, rc, a0, a1, a2, a3, s5, t5, z6, p7, q7;
    logic [255:0] exp5;
    int           cyc;

    initial begin
        rst       = 1'b1;
        dig_ready = 1'b1;
        blk_abc   = '0;
        blk_abc[511:480] = 32'h61626380;
        blk_abc[31:0]    = 32'h00000018;
        b448_1 = 512'h6162636462636465636465666465666765666768666768696768696a68696a6b696a6b6c6a6b6c6d6b6c6d6e6c6d6e6f6d6e6f706e6f70718000000000000000;
        b448_2 = 512'h1c0;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", 512'(req_ready), '0);
        chk("rst_eng_pulses", 512'({eng_start, eng_clr}), '0);
        chk("rst_eng_h", 512'(eng_h), '0);
        chk("rst_eng_m", eng_m, '0);
        chk("rst_dig", 512'({dig_valid, dig_id, dig_data}), '0);
        chk("rst_busy_err", 512'({busy, err}), '0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", 512'(busy), '0);

        // single-block "abc" on requester 0
        send(0, blk_abc, 1'b1, 1'b1);
        expect_dig(0, DIG_ABC);
        wait_digs(1, "t1_digest_count");

        // two-block message on requester 2, chaining value must be used for block 2
        eng_h_log.delete();
        send(2, b448_1, 1'b1, 1'b0);
        send(2, b448_2, 1'b0, 1'b1);
        expect_dig(2, DIG_448);
        wait_digs(2, "t2_digest_count");
        chk("t2_eng_h_count", 512'(eng_h_log.size()), 512'(2));
        chk("t2_eng_h_first", 512'(eng_h_log[0]), 512'(IV));
        chk("t2_eng_h_chain", 512'(eng_h_log[1]), 512'(sha_compress(IV, b448_1)));
        chk("t2_err_clear", 512'(err), '0);

        // continuation block with no open message: hashed from IV, err set; rr_ptr wraps to 0
        ra = rand_block();
        send(3, ra, 1'b0, 1'b1);
        expect_dig(3, sha_compress(IV, ra));
        wait_digs(3, "err_digest_count");
        chk("err_unopened", 512'(err), 512'(1));

        // requesters 1 and 3 together from rr_ptr=0: 1 first, then 3
        rb = rand_block();
        rc = rand_block();
        send(1, rb, 1'b1, 1'b1);
        send(3, rc, 1'b1, 1'b1);
        expect_dig(1, sha_compress(IV, rb));
        expect_dig(3, sha_compress(IV, rc));
        wait_digs(5, "t3_digest_count");

        // three-block message on 0 while 3 waits; rr_ptr back at 0 means 0 wins
        a0 = rand_block();
        a1 = rand_block();
        a2 = rand_block();
        a3 = rand_block();
        lock_base = n_dig;
        chk_lock  = 1'b1;
        send(0, a0, 1'b1, 1'b0);
        send(0, a1, 1'b0, 1'b0);
        send(0, a2, 1'b0, 1'b1);
        send(3, a3, 1'b1, 1'b1);
        expect_dig(0, sha_compress(sha_compress(sha_compress(IV, a0), a1), a2));
        expect_dig(3, sha_compress(IV, a3));
        wait_digs(7, "t4_digest_count");
        chk_lock = 1'b0;

        // consumer back-pressure for 10 cycles with another requester pending
        @(posedge clk);
        #1 dig_ready = 1'b0;
        s5   = rand_block();
        exp5 = sha_compress(IV, s5);
        send(2, s5, 1'b1, 1'b1);
        expect_dig(2, exp5);
        cyc = 0;
        while (!dig_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("t5_valid_seen", 512'(dig_valid), 512'(1));
        t5 = rand_block();
        send(1, t5, 1'b1, 1'b1);
        expect_dig(1, sha_compress(IV, t5));
        repeat (10) begin
            @(negedge clk);
            chk("t5_hold_valid", 512'(dig_valid), 512'(1));
            chk("t5_hold_data", 512'(dig_data), 512'(exp5));
            chk("t5_hold_id", 512'(dig_id), 512'(2));
            chk("t5_no_ready", 512'(req_ready), '0);
            chk("t5_busy", 512'(busy), 512'(1));
        end
        @(posedge clk);
        #1 dig_ready = 1'b1;
        wait_digs(9, "t5_digest_count");

        // reset while the engine is working: everything returns to reset values
        z6 = rand_block();
        send(0, z6, 1'b1, 1'b1);
        cyc = 0;
        while (!eng_start && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("t6_start_seen", 512'(eng_start), 512'(1));
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_req_ready", 512'(req_ready), '0);
        chk("t6_eng_pulses", 512'({eng_start, eng_clr}), '0);
        chk("t6_eng_h", 512'(eng_h), '0);
        chk("t6_eng_m", eng_m, '0);
        chk("t6_dig", 512'({dig_valid, dig_id, dig_data}), '0);
        chk("t6_busy_err", 512'({busy, err}), '0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        send(1, blk_abc, 1'b1, 1'b1);
        expect_dig(1, DIG_ABC);
        wait_digs(10, "t6_digest_count");
        chk("t6_err_clear", 512'(err), '0);

        // owner restarts mid-message: second first=1 block hashes from IV, err set
        p7 = rand_block();
        q7 = rand_block();
        send(0, p7, 1'b1, 1'b0);
        send(0, q7, 1'b1, 1'b1);
        expect_dig(0, sha_compress(IV, q7));
        wait_digs(11, "restart_digest_count");
        chk("restart_err", 512'(err), 512'(1));

        @(negedge clk);
        chk("end_busy", 512'(busy), '0);
        chk("end_exp_q_empty", 512'(exp_q.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
